// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a bounded wait-state timeout
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              Psel,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic expire, done;
  always_comb begin
    expire    = cnt == 8'(TIMEOUT - 1);
    done      = state == ACCESS && (Pready || expire);
    state_n   = state == IDLE ? (cmd_valid ? SETUP : IDLE) :
                state == SETUP ? ACCESS : (done ? IDLE : ACCESS);
    cmd_ready = state == IDLE;
    Psel      = state != IDLE;
    Penable   = state == ACCESS;
  end
  always_ff @(posedge Pclk or negedge Preset)
    if (!Preset) state <= IDLE;
    else state <= state_n;
  // Pready wins over an expiring counter, so a response on the last allowed cycle still succeeds
  always_ff @(posedge Pclk or negedge Preset)
    if (!Preset) begin
      Pwrite      <= 1'b0;
      Paddr       <= '0;
      Pwdata      <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        Pwrite <= cmd_write;
        Paddr  <= cmd_addr;
        Pwdata <= cmd_wdata;
        cnt    <= '0;
      end else if (state == ACCESS && !Pready) cnt <= cnt + 8'd1;
      rsp_valid <= done;
      if (done) begin
        rsp_err     <= Pready ? Pslverr : 1'b1;
        rsp_timeout <= !Pready;
        rsp_rdata   <= (Pready && !Pwrite) ? Prdata : '0;
      end
    end
endmodule
